// File: rtl/cell_cache.sv
// cell_cache: one-frame (or two-frame ping-pong) cell store with a fixed 2-cycle read latency.
// Define CELL_CACHE_PINGPONG_EN for the two-bank build; the default is a single bank.
module cell_cache #(
  parameter  int CELL_WIDTH  = 768,
  parameter  int CELL_NUM    = 1200,
  localparam int CELL_ADDR_W = $clog2(CELL_NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CELL_WIDTH-1:0]  wr_cell_data_i,
  input  logic                   wr_cell_valid_i,
  output logic                   wr_cell_ready_o,
  output logic                   frame_avail_o,
  input  logic [CELL_ADDR_W-1:0] rd_cell_addr_i,
  input  logic                   rd_cell_vld_i,
  output logic [CELL_WIDTH-1:0]  rd_cell_data_o,
  output logic                   rd_cell_rdy_o
);

`ifdef CELL_CACHE_PINGPONG_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

  localparam logic [CELL_ADDR_W-1:0] LAST_ADDR = CELL_ADDR_W'(CELL_NUM - 1);

  logic [CELL_ADDR_W-1:0] wr_cnt;
  logic                   wr_en;
  logic                   wr_last;
  logic                   rd_first;
  logic                   rd_final;
  logic                   rd_in_range;
  logic                   wr_bank;

  assign wr_en       = wr_cell_valid_i & wr_cell_ready_o;
  assign wr_last     = wr_en & (wr_cnt == LAST_ADDR);
  assign rd_first    = rd_cell_vld_i & (rd_cell_addr_i == '0);
  assign rd_final    = rd_cell_vld_i & (rd_cell_addr_i == LAST_ADDR);
  assign rd_in_range = int'(rd_cell_addr_i) < CELL_NUM;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (wr_en) begin
      wr_cnt <= wr_last ? '0 : wr_cnt + CELL_ADDR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage banks; each registers its own read word as the first read stage.
  // ---------------------------------------------------------------------------
  logic [NUM_BANKS-1:0][CELL_WIDTH-1:0] bank_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [CELL_WIDTH-1:0] mem [CELL_NUM];
    logic [CELL_WIDTH-1:0] rd_q;

    // NOTE: the RAM and its output register have no reset so they map onto block
    // memory; reset only clears control state, leaving stored cells in place.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_bank == 1'(b))) begin
        mem[wr_cnt] <= wr_cell_data_i;
      end
      rd_q <= mem[rd_cell_addr_i];
    end

    assign bank_q[b] = rd_q;
  end

  logic                  s1_vld;
  logic                  s1_oor;
  logic [CELL_WIDTH-1:0] s1_word;

`ifdef CELL_CACHE_PINGPONG_EN
  // ---------------------------------------------------------------------------
  // Ping-pong control: writer fills one bank while the reader drains the other.
  // ---------------------------------------------------------------------------
  logic [1:0] full, full_n;
  logic       rd_bank, rd_bank_n;
  logic       wr_bank_q, wr_bank_n;
  logic       addr0_seen, addr0_seen_n;
  logic       s1_bank;

  assign wr_bank = wr_bank_q;
  assign s1_word = bank_q[s1_bank];

  // NOTE: every always_comb output gets a default first so no path infers a latch,
  // and combinational logic uses blocking assignments only.
  always_comb begin
    full_n       = full;
    rd_bank_n    = rd_bank;
    wr_bank_n    = wr_bank_q;
    addr0_seen_n = addr0_seen;
    if (full[rd_bank]) begin
      if (rd_first) addr0_seen_n = 1'b1;
      if (rd_final) begin
        full_n[rd_bank] = 1'b0;
        rd_bank_n       = ~rd_bank;
        addr0_seen_n    = 1'b0;
      end
    end
    // A set here never hits the bank being cleared above: clear needs it full, set needs it empty.
    if (wr_last) begin
      full_n[wr_bank_q] = 1'b1;
      wr_bank_n         = ~wr_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full            <= '0;
      rd_bank         <= 1'b0;
      wr_bank_q       <= 1'b0;
      addr0_seen      <= 1'b0;
      s1_bank         <= 1'b0;
      wr_cell_ready_o <= 1'b0;
      frame_avail_o   <= 1'b0;
    end else begin
      full            <= full_n;
      rd_bank         <= rd_bank_n;
      wr_bank_q       <= wr_bank_n;
      addr0_seen      <= addr0_seen_n;
      s1_bank         <= rd_bank;
      wr_cell_ready_o <= ~full_n[wr_bank_n];
      frame_avail_o   <= full_n[rd_bank_n] & ~addr0_seen_n;
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Single bank: writes stall for the whole readout.
  // ---------------------------------------------------------------------------
  typedef enum logic {WR_ST, RD_ST} state_t;
  state_t state;

  assign wr_bank = 1'b0;
  assign s1_word = bank_q[0];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= WR_ST;
      wr_cell_ready_o <= 1'b0;
      frame_avail_o   <= 1'b0;
    end else begin
      case (state)
        WR_ST: begin
          if (wr_last) begin
            state           <= RD_ST;
            wr_cell_ready_o <= 1'b0;
            frame_avail_o   <= 1'b1;
          end else begin
            wr_cell_ready_o <= 1'b1;
          end
        end
        RD_ST: begin
          if (rd_final) begin
            state           <= WR_ST;
            wr_cell_ready_o <= 1'b1;
            frame_avail_o   <= 1'b0;
          end else if (rd_first) begin
            frame_avail_o   <= 1'b0;
          end
        end
        default: state <= WR_ST;
      endcase
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read pipeline: stage 1 is the bank register above, stage 2 drives the port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld         <= 1'b0;
      s1_oor         <= 1'b0;
      rd_cell_rdy_o  <= 1'b0;
      rd_cell_data_o <= '0;
    end else begin
      s1_vld        <= rd_cell_vld_i;
      s1_oor        <= ~rd_in_range;
      rd_cell_rdy_o <= s1_vld;
      if (s1_vld) begin
        rd_cell_data_o <= s1_oor ? '0 : s1_word;
      end
    end
  end

endmodule

// File: tb/tb_cell_cache.sv
// Self-checking bench for cell_cache: frame-level reference model plus directed literal checks.
// Covers both builds; compile with CELL_CACHE_PINGPONG_EN for the two-bank variant.
module tb_cell_cache;

  localparam int CELL_WIDTH  = 768;
  localparam int CELL_NUM    = 1200;
  localparam int CELL_ADDR_W = $clog2(CELL_NUM);
`ifdef CELL_CACHE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic                   clk;
  logic                   rst;
  logic [CELL_WIDTH-1:0]  wr_cell_data_i;
  logic                   wr_cell_valid_i;
  logic                   wr_cell_ready_o;
  logic                   frame_avail_o;
  logic [CELL_ADDR_W-1:0] rd_cell_addr_i;
  logic                   rd_cell_vld_i;
  logic [CELL_WIDTH-1:0]  rd_cell_data_o;
  logic                   rd_cell_rdy_o;

  cell_cache #(.CELL_WIDTH(CELL_WIDTH), .CELL_NUM(CELL_NUM)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_cell_data_i  (wr_cell_data_i),
    .wr_cell_valid_i (wr_cell_valid_i),
    .wr_cell_ready_o (wr_cell_ready_o),
    .frame_avail_o   (frame_avail_o),
    .rd_cell_addr_i  (rd_cell_addr_i),
    .rd_cell_vld_i   (rd_cell_vld_i),
    .rd_cell_data_o  (rd_cell_data_o),
    .rd_cell_rdy_o   (rd_cell_rdy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [CELL_WIDTH-1:0] act,
                       input logic [CELL_WIDTH-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [CELL_WIDTH-1:0] cell_val(input int tag, input int addr);
    logic [15:0] t, a;
    t = tag[15:0];
    a = addr[15:0];
    return {24{t, a}};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: frames as a count of complete unread buffers.
  // ---------------------------------------------------------------------------
  logic [CELL_WIDTH-1:0] m_mem [NB][CELL_NUM];
  int                    m_full_cnt, m_wcnt, m_wbank, m_rbank;
  bit                    m_seen0, m_ready, m_avail, m_vld1, m_vld2;
  logic [CELL_WIDTH-1:0] m_dat1, m_dat2;

  always @(posedge clk) begin
    if (rst) begin
      m_full_cnt = 0; m_wcnt = 0; m_wbank = 0; m_rbank = 0;
      m_seen0 = 0; m_ready = 0; m_avail = 0; m_vld1 = 0; m_vld2 = 0;
      m_dat1 = '0; m_dat2 = '0;
    end else begin
      int  rd_bank_now;
      bit  frame_ready;
      rd_bank_now = m_rbank;
      frame_ready = m_full_cnt > 0;
      m_vld2 = m_vld1;
      m_dat2 = m_dat1;
      m_vld1 = rd_cell_vld_i;
      m_dat1 = (int'(rd_cell_addr_i) < CELL_NUM) ? m_mem[rd_bank_now][rd_cell_addr_i] : '0;
      if (rd_cell_vld_i && frame_ready) begin
        if (int'(rd_cell_addr_i) == 0) m_seen0 = 1;
        if (int'(rd_cell_addr_i) == CELL_NUM - 1) begin
          m_full_cnt--;
          m_rbank = (m_rbank + 1) % NB;
          m_seen0 = 0;
        end
      end
      if (wr_cell_valid_i && m_ready) begin
        m_mem[m_wbank][m_wcnt] = wr_cell_data_i;
        if (m_wcnt == CELL_NUM - 1) begin
          m_wcnt = 0;
          m_full_cnt++;
          m_wbank = (m_wbank + 1) % NB;
        end else begin
          m_wcnt++;
        end
      end
      m_ready = m_full_cnt < NB;
      m_avail = (m_full_cnt > 0) && !m_seen0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_cell_ready_o", wr_cell_ready_o, m_ready);
      check("frame_avail_o", frame_avail_o, m_avail);
      check("rd_cell_rdy_o", rd_cell_rdy_o, m_vld2);
      if (m_vld2) check("rd_cell_data_o", rd_cell_data_o, m_dat2);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic write_frame(input int tag, input int n);
    int k   = 0;
    int cyc = 0;
    bit acc;
    while (k < n && cyc < 4 * CELL_NUM) begin
      @(negedge clk);
      acc             = wr_cell_ready_o;
      wr_cell_valid_i = 1'b1;
      wr_cell_data_i  = cell_val(tag, k);
      @(posedge clk);
      if (acc) k++;
      cyc++;
    end
    @(negedge clk);
    wr_cell_valid_i = 1'b0;
    check("write_accept_count", k, n);
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      @(negedge clk);
      rd_cell_vld_i  = 1'b1;
      rd_cell_addr_i = CELL_ADDR_W'(a);
    end
    @(negedge clk);
    rd_cell_vld_i = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    wr_cell_data_i  = '0;
    wr_cell_valid_i = 1'b0;
    rd_cell_addr_i  = '0;
    rd_cell_vld_i   = 1'b0;

    // Reset state
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", wr_cell_ready_o, 0);
    check("rst_avail", frame_avail_o, 0);
    check("rst_rdy", rd_cell_rdy_o, 0);
    check("rst_data", rd_cell_data_o, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", wr_cell_ready_o, 1);

    // Frame 1: announce the cycle after the last write
    write_frame(1, CELL_NUM);
    check("f1_avail", frame_avail_o, 1);
    check("f1_ready", wr_cell_ready_o, (NB == 1) ? 1'b0 : 1'b1);

    // Out-of-range read returns zero with a strobe at +2
    @(negedge clk);
    rd_cell_vld_i  = 1'b1;
    rd_cell_addr_i = CELL_ADDR_W'(1300);
    @(negedge clk);
    rd_cell_vld_i  = 1'b0;
    @(negedge clk);
    check("oor_rdy", rd_cell_rdy_o, 1);
    check("oor_data", rd_cell_data_o, '0);
    check("oor_keeps_avail", frame_avail_o, 1);

    // Full back-to-back readout; release the cycle after address CELL_NUM-1
    read_range(0, CELL_NUM - 1);
    check("release_ready", wr_cell_ready_o, 1);
    check("release_avail", frame_avail_o, 0);
    @(negedge clk);
    check("last_rdy", rd_cell_rdy_o, 1);
    check("last_data_lo", rd_cell_data_o[31:0], 32'h0001_04AF);

`ifndef CELL_CACHE_PINGPONG_EN
    // Stale read while writable: old contents, no state effect
    read_range(10, 10);
`endif

    // Frame 2 overwrites from address 0
    write_frame(2, CELL_NUM);
    check("f2_avail", frame_avail_o, 1);
    read_range(0, CELL_NUM - 1);
    @(negedge clk);
    check("f2_last_data_lo", rd_cell_data_o[31:0], 32'h0002_04AF);

    // Reset mid-frame with a read in flight
    write_frame(3, CELL_NUM / 2);
    rd_cell_vld_i  = 1'b1;
    rd_cell_addr_i = CELL_ADDR_W'(3);
    @(negedge clk);
    rd_cell_vld_i  = 1'b0;
    rst            = 1'b1;
    @(negedge clk);
    check("midrst_ready", wr_cell_ready_o, 0);
    check("midrst_avail", frame_avail_o, 0);
    check("midrst_rdy", rd_cell_rdy_o, 0);
    check("midrst_data", rd_cell_data_o, '0);
    rst = 1'b0;

    // Frame 4 after reset is written from address 0 and announced
    write_frame(4, CELL_NUM);
    check("f4_avail", frame_avail_o, 1);
    read_range(0, CELL_NUM - 1);
    @(negedge clk);
    check("f4_last_data_lo", rd_cell_data_o[31:0], 32'h0004_04AF);

`ifdef CELL_CACHE_PINGPONG_EN
    // Frame B is written while frame A drains
    write_frame(5, CELL_NUM);
    fork
      write_frame(6, CELL_NUM);
      begin
        repeat (20) @(negedge clk);
        read_range(0, CELL_NUM - 1);
      end
    join
    check("pp_reannounce", frame_avail_o, 1);
    read_range(0, CELL_NUM - 1);
    @(negedge clk);
    check("pp_b_last_data_lo", rd_cell_data_o[31:0], 32'h0006_04AF);
`endif

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cell_cache.md
# cell_cache

Frame-sized cell store on the responder side of the cell-fetch read interface. Accepts masked-free raw cells in raster order from the frame-fetch/cell-packer path, holds one complete frame, announces it to the cell fetcher, and answers cell read requests with a fixed 2-cycle data latency. It releases the frame for overwrite once the last cell address has been read.

## Interface
- CELL_WIDTH, 768: bits per cell.
- CELL_NUM, 1200: cells per frame (FRAME_ROW_CNUM × FRAME_COL_CNUM).
- CELL_ADDR_W, $clog2(CELL_NUM): derived, not configured.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wr_cell_data_i  in  CELL_WIDTH  incoming cell, raster order.
- wr_cell_valid_i  in  1  incoming cell valid.
- wr_cell_ready_o  out  1  cache can accept a cell.
- frame_avail_o  out  1  complete unread frame present; drives the fetcher's start input.
- rd_cell_addr_i  in  CELL_ADDR_W  read address.
- rd_cell_vld_i  in  1  read request; always accepted, no backpressure.
- rd_cell_data_o  out  CELL_WIDTH  read data.
- rd_cell_rdy_o  out  1  read data valid strobe.

## Operation
- Storage: CELL_NUM × CELL_WIDTH RAM per bank, 1 write port, 1 read port.
- Write counter wr_cnt, 0..CELL_NUM-1. A cell is written when wr_cell_valid_i & wr_cell_ready_o, to address wr_cnt. wr_cnt then increments; it wraps to 0 after CELL_NUM-1 and marks the bank full.
- Bank state FSM with two states:
  - WR_ST: wr_cell_ready_o=1, frame_avail_o=0. Writing CELL_NUM-1 moves the FSM to RD_ST.
  - RD_ST: wr_cell_ready_o=0.
    - frame_avail_o=1 from RD_ST entry until the cycle after a read of address 0 is accepted, then 0.
    - Accepting a read of address CELL_NUM-1 returns the FSM to WR_ST next cycle.
- Read pipeline:
  - Stage 1 registers the RAM output and the bank select.
  - Stage 2 registers the data and the valid strobe.
  - Reads are served in every state. Reads outside RD_ST return stale contents and have no state effect.
- Out-of-range address (≥ CELL_NUM): rd_cell_rdy_o still asserts; data is all zero.
- In-flight reads are unaffected by a bank release or a new write in the same cycle. Read data is captured at request time; the writer cannot reach address CELL_NUM-1 before the last read completes.

## Timing
- Reset values: wr_cell_ready_o=0, frame_avail_o=0, rd_cell_rdy_o=0, rd_cell_data_o=0. The FSM resets to WR_ST with wr_cnt=0. wr_cell_ready_o rises the first cycle after rst deasserts.
- Reset mid-frame discards all stored data and status, and cancels any in-flight read strobes. RAM contents are not cleared.
- Read latency is exactly 2:
  - rd_cell_vld_i high at cycle N gives rd_cell_rdy_o high at N+2, with data for the address sampled at N.
  - Back-to-back requests give back-to-back strobes.
- Frame announce: the last write accepted at cycle N gives frame_avail_o=1 at N+1.
- Release: the read of CELL_NUM-1 at cycle N gives wr_cell_ready_o=1 at N+1 (single-bank build).
- Simultaneous read of address 0 and address CELL_NUM-1 is impossible, since the ports are single-address.

## Configuration
- CELL_CACHE_PINGPONG_EN:
  - Defined: two banks, with wr_bank/rd_bank pointers and full[1:0] flags.
    - wr_cell_ready_o = ~full[wr_bank].
    - Completing a frame sets full[wr_bank] and toggles wr_bank.
    - frame_avail_o follows full[rd_bank] until the read of address 0.
    - The last read clears full[rd_bank] and toggles rd_bank.
    - A set and a clear on different banks in the same cycle both apply.
    - The writer fills the next frame while the reader drains the current one.
  - Undefined: single bank and the two-state FSM above; writes stall for the whole readout.

## Test plan
- Reset, then write 1200 cells with data=address → frame_avail_o=1 the cycle after the 1200th write, and wr_cell_ready_o=0.
- Read addresses 0..1199 back-to-back from frame_avail → rd_cell_rdy_o is continuous from 2 cycles after the first request, data matches each address, and frame_avail_o drops after the read of address 0.
- Read address 1199 → wr_cell_ready_o=1 the next cycle; wr_cnt restarts at 0 and the second frame overwrites correctly.
- Read address 1300 → rd_cell_rdy_o at +2 with data 0.
- Assert rst at write 600 → all outputs 0 next cycle; the next full frame is written from address 0 and announced normally.
- With CELL_CACHE_PINGPONG_EN: write frame B during readout of frame A → no stall; frame_avail_o re-asserts the cycle after A's last read; B's data is intact.
